// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the two-requester register bank.
// Optional feature macro used by the top: ARB_CONTENTION_CNT_EN.
package reg_bank_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_H = 2'd1,
    LOCK_E = 2'd2
  } arb_state_t;

  typedef enum logic {
    HOST   = 1'b0,
    ENGINE = 1'b1
  } side_t;

  // Byte-lane merge: lanes with be=1 take the new data, others keep the old.
  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_rr_arb.sv
// Two-way round-robin grant with the rr pointer flop; in a locked state
// only the lock owner can be granted.
module reg_bank_rr_arb
  import reg_bank_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_req_h,
  input  logic       i_req_e,
  input  arb_state_t i_state,
  output logic       o_grant_h,
  output logic       o_grant_e
);

  side_t r_rr_ptr;

  // Grant selection for the current cycle.
  always_comb begin
    o_grant_h = 1'b0;
    o_grant_e = 1'b0;
    case (i_state)
      ARB: begin
        if (i_req_h && i_req_e) begin
          o_grant_h = (r_rr_ptr == HOST);
          o_grant_e = (r_rr_ptr == ENGINE);
        end else begin
          o_grant_h = i_req_h;
          o_grant_e = i_req_e;
        end
      end
      LOCK_H:  o_grant_h = i_req_h;
      LOCK_E:  o_grant_e = i_req_e;
      default: begin
        o_grant_h = 1'b0;
        o_grant_e = 1'b0;
      end
    endcase
  end

  // Pointer always moves to the side opposite the one just served.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= HOST;
    end else if (o_grant_h) begin
      r_rr_ptr <= ENGINE;
    end else if (o_grant_e) begin
      r_rr_ptr <= HOST;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Byte-enabled register bank shared by host and engine with round-robin
// arbitration and RMW lock. Macro ARB_CONTENTION_CNT_EN builds the contention counter.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int N_REGS   = 8,
  parameter int AW       = 3,
  parameter int LOCK_MAX = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [AW-1:0]            h_address,
  input  logic                     h_read,
  input  logic                     h_write,
  input  logic [DATA_W-1:0]        h_writedata,
  input  logic [BE_W-1:0]          h_byteenable,
  input  logic                     h_lock,
  output logic                     h_waitrequest,
  output logic [DATA_W-1:0]        h_readdata,
  output logic                     h_readdatavalid,
  input  logic [AW-1:0]            e_address,
  input  logic                     e_read,
  input  logic                     e_write,
  input  logic [DATA_W-1:0]        e_writedata,
  input  logic [BE_W-1:0]          e_byteenable,
  input  logic                     e_lock,
  output logic                     e_waitrequest,
  output logic [DATA_W-1:0]        e_readdata,
  output logic                     e_readdatavalid,
  output logic [N_REGS*DATA_W-1:0] reg_q,
  output logic [15:0]              contention_cnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic              w_req_h, w_req_e, w_grant_h, w_grant_e, w_grant;
  logic [AW-1:0]     w_addr;
  logic              w_wr, w_lock;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic [BE_W-1:0]   w_be;
  arb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic [DATA_W-1:0] r_regs [N_REGS];
  logic [DATA_W-1:0] r_h_rdata, r_e_rdata;
  logic              r_h_rvalid, r_e_rvalid;

  assign w_req_h       = h_read | h_write;
  assign w_req_e       = e_read | e_write;
  assign w_grant       = w_grant_h | w_grant_e;
  assign h_waitrequest = w_req_h & ~w_grant_h;
  assign e_waitrequest = w_req_e & ~w_grant_e;

  reg_bank_rr_arb u_rr_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req_h   (w_req_h),
    .i_req_e   (w_req_e),
    .i_state   (r_state),
    .o_grant_h (w_grant_h),
    .o_grant_e (w_grant_e)
  );

  assign w_addr  = w_grant_e ? e_address    : h_address;
  assign w_wdata = w_grant_e ? e_writedata  : h_writedata;
  assign w_be    = w_grant_e ? e_byteenable : h_byteenable;
  assign w_lock  = w_grant_e ? e_lock       : h_lock;
  assign w_wr    = w_grant_e ? e_write      : (w_grant_h & h_write);

  // Out-of-range addresses match no register, so reads return 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_rdata = w_rdata | ({DATA_W{w_addr == AW'(i)}} & r_regs[i]);
    end
  end

  // Register bank write port; out-of-range writes fall through unmatched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (w_wr && (w_addr == AW'(i))) begin
          r_regs[i] <= be_merge(r_regs[i], w_wdata, w_be);
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Read response registered one cycle after the grant edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h_rdata  <= '0;
      r_e_rdata  <= '0;
      r_h_rvalid <= 1'b0;
      r_e_rvalid <= 1'b0;
    end else begin
      r_h_rvalid <= w_grant_h & h_read;
      r_e_rvalid <= w_grant_e & e_read;
      r_h_rdata  <= (w_grant_h && h_read) ? w_rdata : r_h_rdata;
      r_e_rdata  <= (w_grant_e && e_read) ? w_rdata : r_e_rdata;
    end
  end

  assign h_readdata      = r_h_rdata;
  assign h_readdatavalid = r_h_rvalid;
  assign e_readdata      = r_e_rdata;
  assign e_readdatavalid = r_e_rvalid;

  // Lock FSM: the grant that reaches LOCK_MAX completes, then releases.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ARB: begin
        if (w_grant && w_lock && (LOCK_MAX > 1)) begin
          w_state_nxt    = w_grant_h ? LOCK_H : LOCK_E;
          w_lock_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = '0;
        end
      end
      LOCK_H, LOCK_E: begin
        if (w_grant && (!w_lock || (r_lock_cnt >= CNT_W'(LOCK_MAX - 1)))) begin
          w_state_nxt    = ARB;
          w_lock_cnt_nxt = '0;
        end else if (w_grant) begin
          w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end else begin
          w_lock_cnt_nxt = r_lock_cnt;
        end
      end
      default: begin
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state and lock counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
  end

`ifdef ARB_CONTENTION_CNT_EN
  logic [15:0] r_contention_cnt;

  // Saturating count of cycles where both sides request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contention_cnt <= 16'h0000;
    end else if (w_req_h && w_req_e && (r_contention_cnt != 16'hFFFF)) begin
      r_contention_cnt <= r_contention_cnt + 16'h0001;
    end else begin
      r_contention_cnt <= r_contention_cnt;
    end
  end

  assign contention_cnt = r_contention_cnt;
`else
  assign contention_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (N_REGS=6, LOCK_MAX=16).
module tb_reg_bank_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [2:0]   h_address, e_address;
  logic         h_read, h_write, h_lock, e_read, e_write, e_lock;
  logic [31:0]  h_writedata, e_writedata;
  logic [3:0]   h_byteenable, e_byteenable;
  logic         h_waitrequest, h_readdatavalid, e_waitrequest, e_readdatavalid;
  logic [31:0]  h_readdata, e_readdata;
  logic [191:0] reg_q;
  logic [15:0]  contention_cnt;

  int checks   = 0;
  int failures = 0;
  logic [191:0] exp_q;

`ifdef ARB_CONTENTION_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  reg_bank_arbiter #(.N_REGS(6), .AW(3), .LOCK_MAX(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .h_address(h_address), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_byteenable(h_byteenable), .h_lock(h_lock),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
    .e_address(e_address), .e_read(e_read), .e_write(e_write),
    .e_writedata(e_writedata), .e_byteenable(e_byteenable), .e_lock(e_lock),
    .e_waitrequest(e_waitrequest), .e_readdata(e_readdata), .e_readdatavalid(e_readdatavalid),
    .reg_q(reg_q), .contention_cnt(contention_cnt)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    h_read = 1'b0; h_write = 1'b0; h_lock = 1'b0;
    e_read = 1'b0; e_write = 1'b0; e_lock = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    h_address = 3'd0; e_address = 3'd0;
    h_writedata = 32'h0; e_writedata = 32'h0;
    h_byteenable = 4'hF; e_byteenable = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_h_rvalid", h_readdatavalid, 1'b0);
    chk("rst_h_rdata", h_readdata, 32'h0);
    chk("rst_reg_q", reg_q, 192'h0);
    chk("rst_cnt", contention_cnt, 16'h0);
    @(negedge clock) reset_n = 1'b1;
    tick();

    // Both request every cycle: grants alternate H,E,H,E.
    h_read = 1'b1; h_address = 3'd0;
    e_read = 1'b1; e_address = 3'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_h_wait%0d", k), h_waitrequest, (k % 2) != 0);
      chk($sformatf("rr_e_wait%0d", k), e_waitrequest, (k % 2) == 0);
      tick();
    end
    chk("rr_cnt4", contention_cnt, CNT_EN ? 16'd4 : 16'd0);
    chk("rr_e_rvalid", e_readdatavalid, 1'b1);
    chk("rr_h_rvalid", h_readdatavalid, 1'b0);
    idle();
    tick();

    // Host write then read of reg 2.
    h_write = 1'b1; h_address = 3'd2; h_writedata = 32'hDEADBEEF; h_byteenable = 4'hF;
    #1;
    chk("t1_wr_wait", h_waitrequest, 1'b0);
    tick();
    h_write = 1'b0; h_read = 1'b1;
    #1;
    chk("t1_rd_wait", h_waitrequest, 1'b0);
    chk("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
    tick();
    h_read = 1'b0;
    chk("t1_rvalid", h_readdatavalid, 1'b1);
    chk("t1_rdata", h_readdata, 32'hDEADBEEF);
    tick();
    chk("t1_rvalid_pulse", h_readdatavalid, 1'b0);

    // Byte-enabled writes to reg 0.
    h_write = 1'b1; h_address = 3'd0; h_writedata = 32'h11223344; h_byteenable = 4'hF;
    tick();
    h_writedata = 32'hAABBCCDD; h_byteenable = 4'b0101;
    tick();
    chk("t2_be0101", reg_q[31:0], 32'h11BB33DD);
    h_writedata = 32'hFFFFFFFF; h_byteenable = 4'b0000;
    #1;
    chk("t2_be0000_wait", h_waitrequest, 1'b0);
    tick();
    idle();
    chk("t2_be0000_hold", reg_q[31:0], 32'h11BB33DD);

    // Engine locked read then unlocked write while host keeps requesting.
    e_read = 1'b1; e_lock = 1'b1; e_address = 3'd0;
    h_read = 1'b1; h_address = 3'd2;
    #1;
    chk("t4_e_wait0", e_waitrequest, 1'b0);
    chk("t4_h_wait0", h_waitrequest, 1'b1);
    tick();
    e_read = 1'b0; e_write = 1'b1; e_lock = 1'b0; e_address = 3'd1;
    e_writedata = 32'h00005A5A; e_byteenable = 4'hF;
    #1;
    chk("t4_h_wait1", h_waitrequest, 1'b1);
    chk("t4_e_wait1", e_waitrequest, 1'b0);
    chk("t4_e_rvalid", e_readdatavalid, 1'b1);
    chk("t4_e_rdata", e_readdata, 32'h11BB33DD);
    tick();
    e_write = 1'b0;
    #1;
    chk("t4_h_wait2", h_waitrequest, 1'b0);
    tick();
    h_read = 1'b0;
    chk("t4_h_rdata", h_readdata, 32'hDEADBEEF);
    chk("t4_h_rvalid", h_readdatavalid, 1'b1);
    chk("t4_reg1", reg_q[63:32], 32'h00005A5A);
    chk("t4_cnt", contention_cnt, CNT_EN ? 16'd6 : 16'd0);

    // Host holds lock: 16 grants, then forced release to the engine.
    h_read = 1'b1; h_lock = 1'b1; h_address = 3'd0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 2) begin
        e_read = 1'b1; e_address = 3'd0;
      end
      #1;
      chk($sformatf("t5_h_wait%0d", i), h_waitrequest, 1'b0);
      chk($sformatf("t5_e_wait%0d", i), e_waitrequest, i >= 2);
      tick();
    end
    chk("t5_e_wait17", e_waitrequest, 1'b0);
    chk("t5_h_wait17", h_waitrequest, 1'b1);
    tick();
    idle();
    chk("t5_e_rvalid", e_readdatavalid, 1'b1);
    chk("t5_cnt", contention_cnt, CNT_EN ? 16'd22 : 16'd0);

    // Out-of-range write dropped, read returns 0.
    exp_q = '0;
    exp_q[31:0]  = 32'h11BB33DD;
    exp_q[63:32] = 32'h00005A5A;
    exp_q[95:64] = 32'hDEADBEEF;
    h_write = 1'b1; h_address = 3'd7; h_writedata = 32'h12345678; h_byteenable = 4'hF;
    #1;
    chk("t6_oor_wr_wait", h_waitrequest, 1'b0);
    tick();
    chk("t6_oor_wr_drop", reg_q, exp_q);
    h_write = 1'b0; h_read = 1'b1;
    tick();
    h_read = 1'b0;
    chk("t6_oor_rvalid", h_readdatavalid, 1'b1);
    chk("t6_oor_rdata", h_readdata, 32'h0);

    // Reset during a pending read response, request held across reset.
    h_read = 1'b1; h_address = 3'd2;
    tick();
    chk("t6_pre_rst_rvalid", h_readdatavalid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", h_readdatavalid, 1'b0);
    chk("t6_rst_rdata", h_readdata, 32'h0);
    chk("t6_rst_reg_q", reg_q, 192'h0);
    chk("t6_rst_cnt", contention_cnt, 16'h0);
    tick();
    chk("t6_rst_hold_rvalid", h_readdatavalid, 1'b0);
    @(negedge clock) reset_n = 1'b1;
    tick();
    h_read = 1'b0;
    chk("t6_post_rvalid", h_readdatavalid, 1'b1);
    chk("t6_post_rdata", h_readdata, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
